// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter: round-robin arbiter sharing one data-memory port among
// NUM_LSU per-thread LSUs. One transaction is outstanding at a time:
// IDLE (pick requester) -> ISSUE (drive request) -> WAIT (await response)
// -> RESP (one-cycle completion pulse to the granted LSU).
// Optional feature macro: LSU_ARB_PERF_EN adds the 32-bit perf_txn_count
// output counting completed transactions.
module lsu_mem_arbiter #(
  parameter int NUM_LSU              = 4,
  parameter int CACHE_LINE_BYTE_SIZE = 4,
  parameter int DATA_MEM_ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH           = 32
) (
  input  logic                                          clk,
  input  logic                                          reset,
  // LSU side
  input  logic [NUM_LSU-1:0]                            lsu_mem_valid,
  input  logic [NUM_LSU-1:0][DATA_MEM_ADDR_WIDTH-1:0]   lsu_mem_addr,
  input  logic [NUM_LSU-1:0][DATA_WIDTH-1:0]            lsu_mem_data,
  input  logic [NUM_LSU-1:0][CACHE_LINE_BYTE_SIZE-1:0]  lsu_mem_we,
  output logic [NUM_LSU-1:0]                            lsu_mem_resp_ready,
  output logic [DATA_WIDTH-1:0]                         lsu_mem_resp_data,
  // Memory side
  output logic                                          dmem_req_valid,
  input  logic                                          dmem_req_ready,
  output logic [DATA_MEM_ADDR_WIDTH-1:0]                dmem_addr,
  output logic [DATA_WIDTH-1:0]                         dmem_data,
  output logic [CACHE_LINE_BYTE_SIZE-1:0]               dmem_we,
  input  logic                                          dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0]                         dmem_resp_data,
  // Status
`ifdef LSU_ARB_PERF_EN
  output logic [31:0]                                   perf_txn_count,
`endif
  output logic                                          arb_busy
);

  localparam int PTR_W = (NUM_LSU > 1) ? $clog2(NUM_LSU) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                grant_q, grant_d;
  logic [DATA_MEM_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]           data_q, data_d;
  logic [CACHE_LINE_BYTE_SIZE-1:0] we_q, we_d;
  logic [DATA_WIDTH-1:0]           resp_data_q, resp_data_d;

  // Round-robin candidate order: candidate k is (rr_ptr + k) mod NUM_LSU.
  logic [PTR_W:0]   cand_sum  [NUM_LSU];
  logic [PTR_W:0]   cand_wrap [NUM_LSU];
  logic [PTR_W-1:0] cand_idx  [NUM_LSU];
  logic             sel_found;
  logic [PTR_W-1:0] sel_idx;

  generate
    for (genvar gi = 0; gi < NUM_LSU; gi++) begin : g_cand
      assign cand_sum[gi]  = {1'b0, rr_ptr_q} + (PTR_W+1)'(gi);
      assign cand_wrap[gi] = cand_sum[gi] - (PTR_W+1)'(NUM_LSU);
      assign cand_idx[gi]  = (cand_sum[gi] >= (PTR_W+1)'(NUM_LSU))
                             ? cand_wrap[gi][PTR_W-1:0]
                             : cand_sum[gi][PTR_W-1:0];
    end
  endgenerate

  // Pick the first asserted valid, starting at rr_ptr and wrapping upward.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_LSU; k++) begin
      if (!sel_found && lsu_mem_valid[cand_idx[k]]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx[k];
      end
    end
  end

  // State register; reset drops any in-flight transaction without a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: memory stalls simply hold ISSUE or WAIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sel_found)       state_d = S_ISSUE;
      S_ISSUE: if (dmem_req_ready)  state_d = S_WAIT;
      S_WAIT:  if (dmem_resp_valid) state_d = S_RESP;
      S_RESP:                       state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // Request/response register updates. LSU inputs are sampled only at grant,
  // so a requester dropping valid later cannot disturb the transaction.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = we_q;
    resp_data_d = resp_data_q;
    if (state_q == S_IDLE && sel_found) begin
      grant_d = sel_idx;
      addr_d  = lsu_mem_addr[sel_idx];
      data_d  = lsu_mem_data[sel_idx];
      we_d    = lsu_mem_we[sel_idx];
    end
    // Responses outside WAIT are stray and ignored.
    if (state_q == S_WAIT && dmem_resp_valid) begin
      resp_data_d = dmem_resp_data;
    end
    if (state_q == S_RESP) begin
      rr_ptr_d = (grant_q == PTR_W'(NUM_LSU - 1)) ? '0 : grant_q + PTR_W'(1);
    end
  end

  // Datapath registers holding grant, request fields and captured response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= '0;
      resp_data_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Outputs decoded from state and registers only; no input-to-output path.
  always_comb begin
    dmem_req_valid     = (state_q == S_ISSUE);
    arb_busy           = (state_q != S_IDLE);
    dmem_addr          = addr_q;
    dmem_data          = data_q;
    dmem_we            = we_q;
    lsu_mem_resp_data  = resp_data_q;
    lsu_mem_resp_ready = '0;
    for (int i = 0; i < NUM_LSU; i++) begin
      lsu_mem_resp_ready[i] = (state_q == S_RESP) && (grant_q == PTR_W'(i));
    end
  end

`ifdef LSU_ARB_PERF_EN
  logic [31:0] perf_q;

  // Completed-transaction counter, one count per RESP cycle, wraps at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (state_q == S_RESP) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_txn_count = perf_q;
`endif

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: reset, single load, wrap-around,
// all-four round robin, memory stalls, store with reset, optional perf count.
module tb_lsu_mem_arbiter;
  localparam int N  = 4;
  localparam int BE = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         lsu_mem_valid;
  logic [N-1:0][AW-1:0] lsu_mem_addr;
  logic [N-1:0][DW-1:0] lsu_mem_data;
  logic [N-1:0][BE-1:0] lsu_mem_we;
  logic [N-1:0]         lsu_mem_resp_ready;
  logic [DW-1:0]        lsu_mem_resp_data;
  logic                 dmem_req_valid;
  logic                 dmem_req_ready;
  logic [AW-1:0]        dmem_addr;
  logic [DW-1:0]        dmem_data;
  logic [BE-1:0]        dmem_we;
  logic                 dmem_resp_valid;
  logic [DW-1:0]        dmem_resp_data;
  logic                 arb_busy;
`ifdef LSU_ARB_PERF_EN
  logic [31:0]          perf_txn_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  lsu_mem_arbiter #(.NUM_LSU(N), .CACHE_LINE_BYTE_SIZE(BE)) dut (
    .clk(clk),
    .reset(reset),
    .lsu_mem_valid(lsu_mem_valid),
    .lsu_mem_addr(lsu_mem_addr),
    .lsu_mem_data(lsu_mem_data),
    .lsu_mem_we(lsu_mem_we),
    .lsu_mem_resp_ready(lsu_mem_resp_ready),
    .lsu_mem_resp_data(lsu_mem_resp_data),
    .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr),
    .dmem_data(dmem_data),
    .dmem_we(dmem_we),
    .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_data(dmem_resp_data),
`ifdef LSU_ARB_PERF_EN
    .perf_txn_count(perf_txn_count),
`endif
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    lsu_mem_valid   = '0;
    lsu_mem_addr    = '0;
    lsu_mem_data    = '0;
    lsu_mem_we      = '0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Memory-side driver: waits for a request, accepts it after rdy_dly stall
  // cycles, answers rsp_dly cycles later, and models the LSU dropping valid
  // on the edge that samples its pulse. Returns what it observed.
  task automatic serve(input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                       output logic [3:0] pulse, output logic [3:0] after,
                       output logic [31:0] o_addr, output logic [31:0] o_data,
                       output logic [3:0] o_we, output logic [31:0] o_resp,
                       output bit ok);
    int k;
    ok = 1'b0; pulse = '0; after = '0; o_addr = '0; o_data = '0; o_we = '0; o_resp = '0;
    k = 0;
    do begin
      tick();
      k++;
    end while (!dmem_req_valid && k < 20);
    if (dmem_req_valid) begin
      o_addr = dmem_addr; o_data = dmem_data; o_we = dmem_we;
      repeat (rdy_dly) tick();
      dmem_req_ready = 1'b1;
      tick();
      dmem_req_ready = 1'b0;
      repeat (rsp_dly) tick();
      dmem_resp_valid = 1'b1;
      dmem_resp_data  = rdata;
      tick();
      dmem_resp_valid = 1'b0;
      pulse  = lsu_mem_resp_ready;
      o_resp = lsu_mem_resp_data;
      lsu_mem_valid = lsu_mem_valid & ~pulse;
      tick();
      after = lsu_mem_resp_ready;
      ok = 1'b1;
      $display("txn: pulse=%b addr=%h we=%b data=%h resp=%h", pulse, o_addr, o_we, o_data, o_resp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    lsu_mem_valid = 4'hF;
    tick();
    tick();
    n_cmp++; if (dmem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b expected 0", dmem_req_valid); end
    n_cmp++; if (dmem_addr !== 32'h0 || dmem_data !== 32'h0 || dmem_we !== 4'h0) begin n_bad++; $display("FAIL reset_req_regs: got addr=%h data=%h we=%b expected all 0", dmem_addr, dmem_data, dmem_we); end
    n_cmp++; if (lsu_mem_resp_ready !== 4'b0000 || lsu_mem_resp_data !== 32'h0) begin n_bad++; $display("FAIL reset_resp: got ready=%b data=%h expected 0/0", lsu_mem_resp_ready, lsu_mem_resp_data); end
    n_cmp++; if (arb_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", arb_busy); end
    n_cmp++; if (dut.rr_ptr_q !== 2'd0 || dut.grant_q !== 2'd0) begin n_bad++; $display("FAIL reset_ptrs: got rr=%0d grant=%0d expected 0/0", dut.rr_ptr_q, dut.grant_q); end
    lsu_mem_valid = '0;
    reset = 1'b0;
    tick();
    $display("txn: reset checked");
  endtask

  task automatic test_single_load();
    lsu_mem_addr[2] = 32'h40;
    lsu_mem_we[2]   = 4'b0000;
    lsu_mem_valid   = 4'b0100;
    tick();
    n_cmp++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 32'h40 || dmem_we !== 4'b0000) begin n_bad++; $display("FAIL single_issue: got valid=%b addr=%h we=%b expected 1/00000040/0000", dmem_req_valid, dmem_addr, dmem_we); end
    n_cmp++; if (arb_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", arb_busy); end
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    n_cmp++; if (dmem_req_valid !== 1'b0 || lsu_mem_resp_ready !== 4'b0000) begin n_bad++; $display("FAIL single_wait: got valid=%b ready=%b expected 0/0000", dmem_req_valid, lsu_mem_resp_ready); end
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = 32'hDEADBEEF;
    tick();
    dmem_resp_valid = 1'b0;
    n_cmp++; if (lsu_mem_resp_ready !== 4'b0100 || lsu_mem_resp_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL single_pulse: got ready=%b data=%h expected 0100/deadbeef", lsu_mem_resp_ready, lsu_mem_resp_data); end
    lsu_mem_valid = 4'b0000;
    tick();
    n_cmp++; if (lsu_mem_resp_ready !== 4'b0000 || arb_busy !== 1'b0) begin n_bad++; $display("FAIL single_after: got ready=%b busy=%b expected 0000/0", lsu_mem_resp_ready, arb_busy); end
    n_cmp++; if (dut.rr_ptr_q !== 2'd3) begin n_bad++; $display("FAIL single_rr: got %0d expected 3", dut.rr_ptr_q); end
    $display("txn: single load LSU2 done");
  endtask

  task automatic test_wrap();
    logic [3:0] p, a, w;
    logic [31:0] ad, dd, rd;
    bit ok;
    lsu_mem_addr[0] = 32'h1000; lsu_mem_we[0] = 4'b0000;
    lsu_mem_addr[3] = 32'h3000; lsu_mem_we[3] = 4'b0001; lsu_mem_data[3] = 32'hA5A5A5A5;
    lsu_mem_valid = 4'b1001;
    serve(0, 0, 32'h11111111, p, a, ad, dd, w, rd, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_first_timeout: got no request expected one"); end
    n_cmp++; if (p !== 4'b1000 || a !== 4'b0000) begin n_bad++; $display("FAIL wrap_first_grant: got pulse=%b after=%b expected 1000/0000", p, a); end
    n_cmp++; if (ad !== 32'h3000 || w !== 4'b0001 || dd !== 32'hA5A5A5A5 || rd !== 32'h11111111) begin n_bad++; $display("FAIL wrap_first_data: got addr=%h we=%b data=%h resp=%h expected 3000/0001/a5a5a5a5/11111111", ad, w, dd, rd); end
    serve(1, 2, 32'h22222222, p, a, ad, dd, w, rd, ok);
    n_cmp++; if (!ok || p !== 4'b0001 || a !== 4'b0000) begin n_bad++; $display("FAIL wrap_second_grant: got ok=%b pulse=%b after=%b expected 1/0001/0000", ok, p, a); end
    n_cmp++; if (ad !== 32'h1000 || w !== 4'b0000 || rd !== 32'h22222222) begin n_bad++; $display("FAIL wrap_second_data: got addr=%h we=%b resp=%h expected 1000/0000/22222222", ad, w, rd); end
    n_cmp++; if (dut.rr_ptr_q !== 2'd1) begin n_bad++; $display("FAIL wrap_rr: got %0d expected 1", dut.rr_ptr_q); end
  endtask

  task automatic test_all_four();
    logic [3:0] p, a, w;
    logic [31:0] ad, dd, rd;
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) begin
      lsu_mem_addr[i] = 32'h100 * (i + 1);
      lsu_mem_we[i]   = 4'(i);
      lsu_mem_data[i] = 32'hC0DE0000 + i;
    end
    lsu_mem_valid = 4'hF;
    for (int i = 0; i < N; i++) begin
      serve(i % 2, i, 32'hF0000000 + i, p, a, ad, dd, w, rd, ok);
      n_cmp++; if (!ok || p !== 4'(1 << i) || a !== 4'b0000) begin n_bad++; $display("FAIL all4_grant%0d: got ok=%b pulse=%b after=%b expected 1/%b/0000", i, ok, p, a, 4'(1 << i)); end
      n_cmp++; if (ad !== 32'h100 * (i + 1) || w !== 4'(i) || dd !== 32'hC0DE0000 + i || rd !== 32'hF0000000 + i) begin n_bad++; $display("FAIL all4_data%0d: got addr=%h we=%b data=%h resp=%h", i, ad, w, dd, rd); end
    end
    n_cmp++; if (dut.rr_ptr_q !== 2'd0 || arb_busy !== 1'b0) begin n_bad++; $display("FAIL all4_end: got rr=%0d busy=%b expected 0/0", dut.rr_ptr_q, arb_busy); end
  endtask

  task automatic test_stall();
    lsu_mem_addr[1] = 32'h80; lsu_mem_data[1] = 32'h5555AAAA; lsu_mem_we[1] = 4'b0011;
    lsu_mem_valid = 4'b0010;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 32'h80 || dmem_data !== 32'h5555AAAA || dmem_we !== 4'b0011 || lsu_mem_resp_ready !== 4'b0000) begin
        n_bad++; $display("FAIL stall_issue%0d: got valid=%b addr=%h data=%h we=%b ready=%b", c, dmem_req_valid, dmem_addr, dmem_data, dmem_we, lsu_mem_resp_ready);
      end
      dmem_resp_valid = (c == 1 || c == 3);
      dmem_resp_data  = 32'hBAD0BAD0;
      if (c == 2) lsu_mem_addr[1] = 32'hFFFF0000;
      tick();
    end
    dmem_resp_valid = 1'b0;
    n_cmp++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 32'h80) begin n_bad++; $display("FAIL stall_hold: got valid=%b addr=%h expected 1/00000080", dmem_req_valid, dmem_addr); end
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      n_cmp++; if (dmem_req_valid !== 1'b0 || arb_busy !== 1'b1 || lsu_mem_resp_ready !== 4'b0000) begin
        n_bad++; $display("FAIL stall_wait%0d: got valid=%b busy=%b ready=%b expected 0/1/0000", c, dmem_req_valid, arb_busy, lsu_mem_resp_ready);
      end
      tick();
    end
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = 32'h0BADF00D;
    tick();
    dmem_resp_valid = 1'b0;
    n_cmp++; if (lsu_mem_resp_ready !== 4'b0010 || lsu_mem_resp_data !== 32'h0BADF00D) begin n_bad++; $display("FAIL stall_pulse: got ready=%b data=%h expected 0010/0badf00d", lsu_mem_resp_ready, lsu_mem_resp_data); end
    lsu_mem_valid = 4'b0000;
    lsu_mem_addr[1] = 32'h80;
    tick();
    n_cmp++; if (lsu_mem_resp_ready !== 4'b0000 || arb_busy !== 1'b0) begin n_bad++; $display("FAIL stall_after: got ready=%b busy=%b expected 0000/0", lsu_mem_resp_ready, arb_busy); end
    $display("txn: stalled transaction LSU1 done");
  endtask

  task automatic test_store_reset();
    logic [3:0] p, a, w;
    logic [31:0] ad, dd, rd;
    bit ok;
    lsu_mem_addr[1] = 32'h100; lsu_mem_data[1] = 32'h12341234; lsu_mem_we[1] = 4'b1100;
    lsu_mem_valid = 4'b0010;
    tick();
    n_cmp++; if (dmem_req_valid !== 1'b1 || dmem_we !== 4'b1100 || dmem_data !== 32'h12341234) begin n_bad++; $display("FAIL store_issue: got valid=%b we=%b data=%h expected 1/1100/12341234", dmem_req_valid, dmem_we, dmem_data); end
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    n_cmp++; if (arb_busy !== 1'b1 || dmem_req_valid !== 1'b0) begin n_bad++; $display("FAIL store_wait: got busy=%b valid=%b expected 1/0", arb_busy, dmem_req_valid); end
    lsu_mem_valid = 4'b0000;
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (dmem_req_valid !== 1'b0 || dmem_addr !== 32'h0 || dmem_data !== 32'h0 || dmem_we !== 4'h0) begin n_bad++; $display("FAIL store_rst_req: got valid=%b addr=%h data=%h we=%b expected all 0", dmem_req_valid, dmem_addr, dmem_data, dmem_we); end
    n_cmp++; if (lsu_mem_resp_ready !== 4'h0 || lsu_mem_resp_data !== 32'h0 || arb_busy !== 1'b0) begin n_bad++; $display("FAIL store_rst_resp: got ready=%b data=%h busy=%b expected 0/0/0", lsu_mem_resp_ready, lsu_mem_resp_data, arb_busy); end
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = 32'h77777777;
    tick();
    dmem_resp_valid = 1'b0;
    reset = 1'b0;
    n_cmp++; if (lsu_mem_resp_ready !== 4'h0 || arb_busy !== 1'b0) begin n_bad++; $display("FAIL store_rst_hold: got ready=%b busy=%b expected 0000/0", lsu_mem_resp_ready, arb_busy); end
    tick();
    n_cmp++; if (lsu_mem_resp_ready !== 4'h0 || arb_busy !== 1'b0 || dut.rr_ptr_q !== 2'd0) begin n_bad++; $display("FAIL store_rst_release: got ready=%b busy=%b rr=%0d expected 0000/0/0", lsu_mem_resp_ready, arb_busy, dut.rr_ptr_q); end
    lsu_mem_valid = 4'b0010;
    serve(0, 0, 32'h0, p, a, ad, dd, w, rd, ok);
    n_cmp++; if (!ok || p !== 4'b0010 || a !== 4'b0000) begin n_bad++; $display("FAIL store_fresh_grant: got ok=%b pulse=%b after=%b expected 1/0010/0000", ok, p, a); end
    n_cmp++; if (ad !== 32'h100 || w !== 4'b1100 || dd !== 32'h12341234) begin n_bad++; $display("FAIL store_fresh_data: got addr=%h we=%b data=%h expected 100/1100/12341234", ad, w, dd); end
    n_cmp++; if (dut.rr_ptr_q !== 2'd2) begin n_bad++; $display("FAIL store_fresh_rr: got %0d expected 2", dut.rr_ptr_q); end
  endtask

`ifdef LSU_ARB_PERF_EN
  task automatic test_perf();
    logic [3:0] p, a, w;
    logic [31:0] ad, dd, rd;
    bit ok;
    do_reset();
    n_cmp++; if (perf_txn_count !== 32'd0) begin n_bad++; $display("FAIL perf_reset: got %0d expected 0", perf_txn_count); end
    for (int t = 0; t < 10; t++) begin
      lsu_mem_valid = 4'(1 << (t % 4));
      serve(0, 0, 32'h0, p, a, ad, dd, w, rd, ok);
    end
    n_cmp++; if (perf_txn_count !== 32'd10) begin n_bad++; $display("FAIL perf_count: got %0d expected 10", perf_txn_count); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_load();
    test_wrap();
    test_all_four();
    test_stall();
    test_store_reset();
`ifdef LSU_ARB_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
